// File: rtl/scan_test_ctrl_if.sv
// ---------------------------------------------------------------------------
// scan_test_ctrl_if
//   Bundles every non-clock signal of the scan test controller.
//   Host side:  start / num_patterns / seed in, busy / done / signature out.
//   CUT side:   NbarT / Si / CE / pi out to the netlist, So / po back.
//   modport slave  : the controller's view.
//   modport master : the environment's view (host + circuit under test).
// ---------------------------------------------------------------------------
interface scan_test_ctrl_if #(
    parameter int PI_W = 4,
    parameter int PO_W = 4
);
    logic            start;
    logic [15:0]     num_patterns;
    logic [15:0]     seed;
    logic            So;
    logic [PO_W-1:0] po;
    logic            NbarT;
    logic            Si;
    logic            CE;
    logic [PI_W-1:0] pi;
    logic            busy;
    logic            done;
    logic [15:0]     signature;

    modport slave (
        input  start, num_patterns, seed, So, po,
        output NbarT, Si, CE, pi, busy, done, signature
    );

    modport master (
        output start, num_patterns, seed, So, po,
        input  NbarT, Si, CE, pi, busy, done, signature
    );
endinterface

// File: rtl/scan_test_ctrl.sv
// ---------------------------------------------------------------------------
// scan_test_ctrl
//   Built-in scan test driver. For each pattern it shifts CHAIN_LEN LFSR bits
//   into the scan chain (NbarT=1), applies LFSR-derived primary inputs for one
//   settling cycle, pulses one capture cycle (CE=1), and compacts the scan-out
//   stream plus primary outputs into a 16-bit MISR. A final unload drains the
//   last captured state into the MISR.
//
// Ports
//   C    : clock, rising edge
//   R    : asynchronous active-high reset
//   bus  : scan_test_ctrl_if.slave
//          start/num_patterns/seed  - run request (sampled in IDLE/DONE)
//          So/po                    - scan-out and primary outputs of the CUT
//          NbarT/Si/CE/pi           - scan enable, scan-in, capture, PI drive
//          busy/done/signature      - status and MISR contents
// ---------------------------------------------------------------------------
module scan_test_ctrl #(
    parameter int CHAIN_LEN = 8,
    parameter int PI_W      = 4,
    parameter int PO_W      = 4
) (
    input  logic               C,
    input  logic               R,
    scan_test_ctrl_if.slave    bus
);

    localparam int SH_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [SH_W-1:0] SH_LAST = SH_W'(CHAIN_LEN - 1);

    localparam logic [15:0] LFSR_POLY  = 16'hB400;
    localparam logic [15:0] MISR_POLY  = 16'h1021;
    localparam logic [15:0] SEED_ALT   = 16'hACE1;
    localparam logic [15:0] LFSR_RESET = 16'h0001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_APPLY,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t          state,    state_nxt;
    logic [15:0]     lfsr,     lfsr_nxt;
    logic [15:0]     misr,     misr_nxt;
    logic [15:0]     pat_cnt,  pat_nxt;
    logic [15:0]     npat,     npat_nxt;
    logic [SH_W-1:0] sh_cnt,   sh_nxt;
    logic [PI_W-1:0] pi_q,     pi_nxt;

    // Registered outputs, loaded from the next-state decode so that every
    // output pin comes straight from a flop.
    logic            nbart_q,  nbart_nxt;
    logic            si_q,     si_nxt;
    logic            ce_q,     ce_nxt;
    logic            busy_q,   busy_nxt;
    logic            done_q,   done_nxt;

    logic [15:0]     lfsr_adv;
    logic [15:0]     pat_inc;
    logic [15:0]     so_word;
    logic [15:0]     po_word;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_POLY : 16'h0000);
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m,
                                              input logic [15:0] d);
        return {m[14:0], 1'b0} ^ (m[15] ? MISR_POLY : 16'h0000) ^ d;
    endfunction

    assign lfsr_adv = lfsr_step(lfsr);
    assign pat_inc  = pat_cnt + 16'd1;
    assign so_word  = {15'b0, bus.So};
    assign po_word  = 16'(bus.po);

    // ------------------------------------------------------------------
    // Next-state / next-datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        misr_nxt  = misr;
        pat_nxt   = pat_cnt;
        npat_nxt  = npat;
        sh_nxt    = sh_cnt;
        pi_nxt    = pi_q;

        unique case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    lfsr_nxt  = (bus.seed == 16'h0000) ? SEED_ALT : bus.seed;
                    misr_nxt  = 16'h0000;
                    pat_nxt   = 16'h0000;
                    sh_nxt    = '0;
                    npat_nxt  = bus.num_patterns;
                    state_nxt = (bus.num_patterns == 16'h0000) ? S_DONE : S_SHIFT;
                end
            end

            S_SHIFT: begin
                lfsr_nxt = lfsr_adv;
                // The chain holds garbage before the first capture, so the
                // first load's scan-out is not compacted.
                if (pat_cnt != 16'h0000)
                    misr_nxt = misr_step(misr, so_word);
                if (sh_cnt == SH_LAST) begin
                    sh_nxt    = '0;
                    pi_nxt    = lfsr_adv[PI_W-1:0];
                    state_nxt = S_APPLY;
                end else begin
                    sh_nxt = sh_cnt + 1'b1;
                end
            end

            S_APPLY: begin
                state_nxt = S_CAPTURE;
            end

            S_CAPTURE: begin
                misr_nxt  = misr_step(misr, po_word);
                pat_nxt   = pat_inc;
                state_nxt = (pat_inc == npat) ? S_UNLOAD : S_SHIFT;
            end

            S_UNLOAD: begin
                misr_nxt = misr_step(misr, so_word);
                if (sh_cnt == SH_LAST) begin
                    sh_nxt    = '0;
                    state_nxt = S_DONE;
                end else begin
                    sh_nxt = sh_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Output decode of the state being entered.
        nbart_nxt = (state_nxt == S_SHIFT) || (state_nxt == S_UNLOAD);
        si_nxt    = (state_nxt == S_SHIFT) ? lfsr_nxt[0] : 1'b0;
        ce_nxt    = (state_nxt == S_CAPTURE);
        busy_nxt  = (state_nxt == S_SHIFT)   || (state_nxt == S_APPLY) ||
                    (state_nxt == S_CAPTURE) || (state_nxt == S_UNLOAD);
        done_nxt  = (state_nxt == S_DONE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state   <= S_IDLE;
            lfsr    <= LFSR_RESET;
            misr    <= 16'h0000;
            pat_cnt <= 16'h0000;
            npat    <= 16'h0000;
            sh_cnt  <= '0;
            pi_q    <= '0;
            nbart_q <= 1'b0;
            si_q    <= 1'b0;
            ce_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            lfsr    <= lfsr_nxt;
            misr    <= misr_nxt;
            pat_cnt <= pat_nxt;
            npat    <= npat_nxt;
            sh_cnt  <= sh_nxt;
            pi_q    <= pi_nxt;
            nbart_q <= nbart_nxt;
            si_q    <= si_nxt;
            ce_q    <= ce_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    assign bus.NbarT     = nbart_q;
    assign bus.Si        = si_q;
    assign bus.CE        = ce_q;
    assign bus.pi        = pi_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.signature = misr;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scan_test_ctrl
//   Directed bench for scan_test_ctrl (CHAIN_LEN=8, PI_W=4, PO_W=4). So and po
//   are held at constants per run so that expected MISR signatures can be
//   worked out by hand.
// ---------------------------------------------------------------------------
module tb_scan_test_ctrl;

    localparam int CHAIN_LEN = 8;
    localparam int PI_W      = 4;
    localparam int PO_W      = 4;

    logic C;
    logic R;

    scan_test_ctrl_if #(.PI_W(PI_W), .PO_W(PO_W)) bus ();

    scan_test_ctrl #(
        .CHAIN_LEN (CHAIN_LEN),
        .PI_W      (PI_W),
        .PO_W      (PO_W)
    ) dut (
        .C   (C),
        .R   (R),
        .bus (bus)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    int errors = 0;
    int checks = 0;

    // Activity monitor, sampled mid-cycle.
    int   busy_cnt = 0;
    int   ce_cnt   = 0;
    int   apply_ok = 0;
    logic prev_apply = 1'b0;

    always @(negedge C) begin
        if (bus.busy) busy_cnt++;
        if (bus.CE) begin
            ce_cnt++;
            if (prev_apply) apply_ok++;
        end
        prev_apply = bus.busy && !bus.NbarT && !bus.CE;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        busy_cnt = 0;
        ce_cnt   = 0;
        apply_ok = 0;
    endtask

    // Called at posedge+2; returns at posedge+2 of the first cycle after the
    // accepting edge.
    task automatic start_run(input logic [15:0] n, input logic [15:0] s);
        clr_mon();
        bus.start        = 1'b1;
        bus.num_patterns = n;
        bus.seed         = s;
        @(posedge C); #2;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!bus.done && k < 200) begin
            @(negedge C); #1;
            k++;
        end
        chk(tag, {31'b0, bus.done}, 32'd1);
    endtask

    task automatic align();
        @(posedge C); #2;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] si_vec;
    logic       nbt_all;

    initial begin
        R                = 1'b1;
        bus.start        = 1'b0;
        bus.num_patterns = 16'd0;
        bus.seed         = 16'd0;
        bus.So           = 1'b0;
        bus.po           = '0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge C);
        chk("rst_nbart", {31'b0, bus.NbarT}, 32'd0);
        chk("rst_busy",  {31'b0, bus.busy},  32'd0);
        chk("rst_done",  {31'b0, bus.done},  32'd0);
        chk("rst_ce",    {31'b0, bus.CE},    32'd0);
        chk("rst_pi",    {28'b0, bus.pi},    32'd0);
        chk("rst_sig",   {16'b0, bus.signature}, 32'd0);
        align();
        R = 1'b0;
        align();

        // ---------------- num_patterns = 0 ----------------
        start_run(16'd0, 16'h1234);
        @(negedge C);
        chk("n0_done", {31'b0, bus.done}, 32'd1);
        chk("n0_busy", {31'b0, bus.busy}, 32'd0);
        chk("n0_sig",  {16'b0, bus.signature}, 32'd0);
        @(negedge C);
        chk("n0_busy_cnt", busy_cnt, 32'd0);
        align();

        // ---------------- seed=1, N=1, So=0, po=1 (start from DONE) -------
        bus.So = 1'b0;
        bus.po = 4'h1;
        start_run(16'd1, 16'h0001);
        nbt_all = 1'b1;
        for (int k = 0; k < CHAIN_LEN; k++) begin
            @(negedge C);
            si_vec[k] = bus.Si;
            nbt_all   = nbt_all & bus.NbarT;
            if (k == 0) chk("t1_done_drop", {31'b0, bus.done}, 32'd0);
        end
        chk("t1_si_seq",   {24'b0, si_vec},  32'h01);
        chk("t1_shift_nbt", {31'b0, nbt_all}, 32'd1);
        @(negedge C);
        chk("t1_apply_nbt", {31'b0, bus.NbarT}, 32'd0);
        chk("t1_apply_ce",  {31'b0, bus.CE},    32'd0);
        chk("t1_apply_pi",  {28'b0, bus.pi},    32'h8);
        @(negedge C);
        chk("t1_cap_ce",    {31'b0, bus.CE},    32'd1);
        wait_done("t1_done");
        chk("t1_sig",      {16'b0, bus.signature}, 32'h0100);
        chk("t1_busy_cnt", busy_cnt, 32'd18);
        chk("t1_ce_cnt",   ce_cnt,   32'd1);
        chk("t1_done_nbt", {31'b0, bus.NbarT}, 32'd0);
        chk("t1_pi_held",  {28'b0, bus.pi},    32'h8);
        align();

        // ---------------- N=2, So=0, po=0 ----------------
        bus.po = 4'h0;
        start_run(16'd2, 16'h0001);
        wait_done("t2_done");
        chk("t2_sig",      {16'b0, bus.signature}, 32'h0000);
        chk("t2_busy_cnt", busy_cnt, 32'd28);
        chk("t2_ce_cnt",   ce_cnt,   32'd2);
        chk("t2_apply_ok", apply_ok, 32'd2);
        align();

        // ---------------- N=1, So=1, po=0, start during CAPTURE/UNLOAD ----
        bus.So = 1'b1;
        start_run(16'd1, 16'h0001);
        repeat (CHAIN_LEN + 1) @(posedge C);
        #2;
        chk("t3_in_capture", {31'b0, bus.CE}, 32'd1);
        bus.start        = 1'b1;
        bus.num_patterns = 16'd5;
        @(posedge C); #2;
        bus.start = 1'b0;
        chk("t3_in_unload", {31'b0, bus.NbarT}, 32'd1);
        bus.start = 1'b1;
        @(posedge C); #2;
        bus.start = 1'b0;
        wait_done("t3_done");
        chk("t3_sig",      {16'b0, bus.signature}, 32'h00FF);
        chk("t3_busy_cnt", busy_cnt, 32'd18);
        chk("t3_ce_cnt",   ce_cnt,   32'd1);
        align();

        // ---------------- N=2, So=1, po=0 (MISR feedback tap) ------------
        start_run(16'd2, 16'h0001);
        wait_done("t4_done");
        chk("t4_sig",      {16'b0, bus.signature}, 32'hEEDE);
        chk("t4_busy_cnt", busy_cnt, 32'd28);
        align();

        // ---------------- seed=0 -> LFSR = ACE1 ----------------
        bus.So = 1'b0;
        bus.po = 4'h1;
        start_run(16'd1, 16'h0000);
        @(negedge C);
        chk("t5_si0", {31'b0, bus.Si}, 32'd1);
        @(negedge C);
        chk("t5_si1", {31'b0, bus.Si}, 32'd0);
        wait_done("t5_done");
        chk("t5_sig", {16'b0, bus.signature}, 32'h0100);
        align();

        // ---------------- reset mid-SHIFT (N=3) ----------------
        bus.So = 1'b1;
        bus.po = 4'h0;
        start_run(16'd3, 16'h0001);
        repeat (12) @(posedge C);
        #2;
        chk("t6_sig_pre", {16'b0, bus.signature}, 32'h0003);
        R = 1'b1;
        #1;
        chk("t6_rst_nbt",  {31'b0, bus.NbarT}, 32'd0);
        chk("t6_rst_busy", {31'b0, bus.busy},  32'd0);
        chk("t6_rst_sig",  {16'b0, bus.signature}, 32'd0);
        chk("t6_rst_pi",   {28'b0, bus.pi},    32'd0);
        align();
        R = 1'b0;
        align();
        bus.So = 1'b0;
        bus.po = 4'h1;
        start_run(16'd1, 16'h0001);
        wait_done("t6_done");
        chk("t6_sig",      {16'b0, bus.signature}, 32'h0100);
        chk("t6_busy_cnt", busy_cnt, 32'd18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
